// File: rtl/regfile_2w2r.sv
// regfile_2w2r: parametrised two-write / two-read register file with an
// optional hardwired-zero register 0, optional write-to-read bypass,
// optional registered reads and a one-register-per-cycle clear sweep.
//
// Ports:
//   sys_clk        clock, all state updates on the rising edge
//   sys_rst_n      synchronous active-low reset
//   ra1, ra2       read addresses
//   rd1, rd2       read data (combinational, or registered when READ_REG=1)
//   we0/wa0/wd0    write port 0
//   we1/wa1/wd1    write port 1 (wins over port 0 on an address collision)
//   clr_req        single-cycle pulse that starts the clear sweep
//   busy           high while the clear sweep runs
module regfile_2w2r #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 0,
    parameter int unsigned READ_REG = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   rf [DEPTH];

    logic                wr0_ok;
    logic                wr1_ok;
    logic                byp_ok;
    logic [DATA_W-1:0]   sel1;
    logic [DATA_W-1:0]   sel2;

    // Port write qualification; address 0 is read-only when hardwired to zero.
    always_comb begin
        wr0_ok = we0;
        wr1_ok = we1;
        if (ZERO_REG != 0) begin
            if (wa0 == '0) wr0_ok = 1'b0;
            if (wa1 == '0) wr1_ok = 1'b0;
        end
    end

    // Array, sweep counter and clear FSM.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf[ADDR_W'(i)] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        // A clear request wins over any same-cycle write.
                        rf['0] <= '0;
                        cnt    <= ADDR_W'(1);
                        busy   <= 1'b1;
                        state  <= SWEEP;
                    end else begin
                        // Port 1 is assigned last so it wins on a collision.
                        if (wr0_ok) rf[wa0] <= wd0;
                        if (wr1_ok) rf[wa1] <= wd1;
                    end
                end
                SWEEP: begin
                    rf[cnt] <= '0;
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Writes are dropped during a sweep, so bypass must not forward them.
    assign byp_ok = (BYPASS != 0) && !busy;

    // Read-port selection: array, then bypass (port 1 over port 0), then zero.
    always_comb begin
        sel1 = rf[ra1];
        if (byp_ok && we0 && (wa0 == ra1)) sel1 = wd0;
        if (byp_ok && we1 && (wa1 == ra1)) sel1 = wd1;
        if ((ZERO_REG != 0) && (ra1 == '0)) sel1 = '0;

        sel2 = rf[ra2];
        if (byp_ok && we0 && (wa0 == ra2)) sel2 = wd0;
        if (byp_ok && we1 && (wa1 == ra2)) sel2 = wd1;
        if ((ZERO_REG != 0) && (ra2 == '0)) sel2 = '0;
    end

    // Output stage: registered or pass-through.
    generate
        if (READ_REG != 0) begin : g_rd_reg
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) begin
                    rd1 <= '0;
                    rd2 <= '0;
                end else begin
                    rd1 <= sel1;
                    rd2 <= sel2;
                end
            end
        end else begin : g_rd_comb
            assign rd1 = sel1;
            assign rd2 = sel2;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_2w2r.sv
// Randomised plus directed bench for regfile_2w2r. Four configurations run
// side by side on shared stimulus; a reference model per configuration pushes
// expected outputs into a scoreboard that a monitor drains on each falling edge.
module tb_regfile_2w2r;

    // cfg0: plain; cfg1: zero+bypass; cfg2: bypass+regread; cfg3: zero+regread
    localparam bit [3:0] CZ = 4'b1010;
    localparam bit [3:0] CB = 4'b0110;
    localparam bit [3:0] CR = 4'b1100;

    logic       clk;
    logic       rst_n;
    logic [2:0] ra1, ra2, wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       we0, we1, clr_req;

    logic [3:0][7:0] d_rd1;
    logic [3:0][7:0] d_rd2;
    logic [3:0]      d_busy;

    regfile_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0), .READ_REG(0)) u_c0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ra1(ra1), .ra2(ra2),
        .rd1(d_rd1[0]), .rd2(d_rd2[0]), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .clr_req(clr_req), .busy(d_busy[0]));
    regfile_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u_c1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ra1(ra1), .ra2(ra2),
        .rd1(d_rd1[1]), .rd2(d_rd2[1]), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .clr_req(clr_req), .busy(d_busy[1]));
    regfile_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1), .READ_REG(1)) u_c2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ra1(ra1), .ra2(ra2),
        .rd1(d_rd1[2]), .rd2(d_rd2[2]), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .clr_req(clr_req), .busy(d_busy[2]));
    regfile_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0), .READ_REG(1)) u_c3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .ra1(ra1), .ra2(ra2),
        .rd1(d_rd1[3]), .rd2(d_rd2[3]), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .clr_req(clr_req), .busy(d_busy[3]));

    typedef struct packed {
        logic [3:0][7:0] rd1;
        logic [3:0][7:0] rd2;
        logic            busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total;
    int   bad;

    // Reference model state
    logic [7:0] m_rf [4][8];
    logic [7:0] m_r1 [4];
    logic [7:0] m_r2 [4];
    bit         m_sweep;
    int         m_idx;

    // Clock starts high so the first check falls before the first edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] sel(input int c, input logic [2:0] ra);
        if (CZ[c] && ra == 3'd0) return 8'h00;
        if (CB[c] && !m_sweep && we1 && wa1 == ra) return wd1;
        if (CB[c] && !m_sweep && we0 && wa0 == ra) return wd0;
        return m_rf[c][ra];
    endfunction

    task automatic push_exp();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            e.rd1[c] = CR[c] ? m_r1[c] : sel(c, ra1);
            e.rd2[c] = CR[c] ? m_r2[c] : sel(c, ra2);
        end
        e.busy = m_sweep;
        sb.push_back(e);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                for (int a = 0; a < 8; a++) m_rf[c][a] = 8'h00;
                m_r1[c] = 8'h00;
                m_r2[c] = 8'h00;
            end
            m_sweep = 0;
            m_idx   = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_r1[c] = sel(c, ra1);
                m_r2[c] = sel(c, ra2);
            end
            if (m_sweep) begin
                for (int c = 0; c < 4; c++) m_rf[c][m_idx] = 8'h00;
                m_idx++;
                if (m_idx == 8) m_sweep = 0;
            end else if (clr_req) begin
                for (int c = 0; c < 4; c++) m_rf[c][0] = 8'h00;
                m_idx   = 1;
                m_sweep = 1;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (we0 && !(CZ[c] && wa0 == 3'd0)) m_rf[c][wa0] = wd0;
                    if (we1 && !(CZ[c] && wa1 == 3'd0)) m_rf[c][wa1] = wd1;
                end
            end
        end
    endtask

    // One cycle: record expectation for current inputs, then advance the model.
    task automatic apply();
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        rst_n = 1'b1; we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1; wa0 = 3'(i); wd0 = 8'(i + 1); ra1 = 3'(i);
            apply();
        end
        we0 = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            apply();
        end
    endtask

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cfg%0d got=%h want=%h at %0t", name, c, act, want, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                for (int c = 0; c < 4; c++) begin
                    check("rd1", c, d_rd1[c], mon_e.rd1[c]);
                    check("rd2", c, d_rd2[c], mon_e.rd2[c]);
                    check("busy", c, {7'd0, d_busy[c]}, {7'd0, mon_e.busy});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; clr_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0; wa0 = 3'd0; wa1 = 3'd0; wd0 = 8'h00; wd1 = 8'h00;
        ra1 = 3'd0; ra2 = 3'd0;
        @(posedge clk);
        model_edge();
        #1;
        apply();                       // second reset edge
        quiet();
        read_all();

        // Dual write to distinct addresses, then a collision on address 3
        we0 = 1'b1; wa0 = 3'd2; wd0 = 8'h11; we1 = 1'b1; wa1 = 3'd5; wd1 = 8'h22;
        ra1 = 3'd2; ra2 = 3'd5;
        apply();
        wa0 = 3'd3; wd0 = 8'hAA; wa1 = 3'd3; wd1 = 8'h55; ra1 = 3'd3; ra2 = 3'd2;
        apply();
        quiet(); ra1 = 3'd2; ra2 = 3'd5; apply();
        ra1 = 3'd3; apply();

        // Same-cycle read of a written address
        ra1 = 3'd4; we0 = 1'b1; wa0 = 3'd4; wd0 = 8'h3C;
        apply();
        quiet(); apply(); apply();

        // Writes to address 0, with bypass-eligible reads of address 0
        ra1 = 3'd0; ra2 = 3'd0;
        we0 = 1'b1; wa0 = 3'd0; wd0 = 8'hFF;
        apply();
        we0 = 1'b0; we1 = 1'b1; wa1 = 3'd0; wd1 = 8'hEE;
        apply();
        quiet(); apply(); apply();

        // Clear sweep with ignored mid-sweep write and clear request
        fill();
        clr_req = 1'b1; ra1 = 3'd6; ra2 = 3'd7;
        apply();
        clr_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            ra1 = 3'(k); ra2 = 3'd6;
            if (k == 3) begin
                we0 = 1'b1; wa0 = 3'd6; wd0 = 8'h99;
                we1 = 1'b1; wa1 = 3'd2; wd1 = 8'h98;
            end
            clr_req = (k == 4);
            apply();
            quiet();
        end
        we0 = 1'b1; wa0 = 3'd6; wd0 = 8'h99; ra2 = 3'd6;
        apply();
        quiet();
        read_all();

        // Reset on the third busy cycle
        fill();
        clr_req = 1'b1; apply(); clr_req = 1'b0;
        apply(); apply();
        rst_n = 1'b0; apply();
        quiet();
        read_all();

        // Registered read latency
        we0 = 1'b1; wa0 = 3'd5; wd0 = 8'h77; ra2 = 3'd1;
        apply();
        quiet(); ra2 = 3'd5; apply(); apply();

        // Randomised traffic with collisions, occasional clears and resets
        repeat (600) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            clr_req = ($urandom_range(0, 39) == 0);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = 3'($urandom);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 3'($urandom);
            wd0 = 8'($urandom);
            wd1 = 8'($urandom);
            ra1 = ($urandom_range(0, 2) == 0) ? wa0 : 3'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? wa1 : 3'($urandom);
            apply();
        end
        quiet();
        apply(); apply();
        read_all();

        @(negedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
